// File: rtl/wb_stage_if.sv
// Write-back stage bus: upstream instruction handoff, data-memory response
// and the register-file write port driven towards decode.
interface wb_stage_if #(parameter int unsigned XLEN = 64);
  logic            valid_in;
  logic            ready_in;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      rd_addr_in;
  logic            reg_write_in;
  logic            mem_read;
  logic [2:0]      funct3;
  logic [2:0]      addr_lo;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            reg_write;
  logic            retire;

  modport master (
    output valid_in, alu_result, rd_addr_in, reg_write_in, mem_read, funct3,
           addr_lo, mem_rsp_valid, mem_rsp_data,
    input  ready_in, rd_addr, rd_data, reg_write, retire
  );

  modport slave (
    input  valid_in, alu_result, rd_addr_in, reg_write_in, mem_read, funct3,
           addr_lo, mem_rsp_valid, mem_rsp_data,
    output ready_in, rd_addr, rd_data, reg_write, retire
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: accepts one retiring instruction, waits for load data,
// extracts/extends it and pulses the register-file write. Option: WB_INSTRET_EN.
module wb_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
  state_t state, state_next;

  logic [4:0]      rd_addr_q, rd_pend;
  logic [XLEN-1:0] rd_data_q, shifted, load_data;
  logic            wr_q, wr_pend;
  logic [2:0]      f3_pend, lo_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.valid_in) state_next = bus.mem_read ? WAIT_MEM : COMMIT;
      WAIT_MEM: if (bus.mem_rsp_valid) state_next = COMMIT;
      COMMIT:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_in  = 1'b0;
    bus.reg_write = 1'b0;
    bus.retire    = 1'b0;
    bus.rd_addr   = rd_addr_q;
    bus.rd_data   = rd_data_q;
    case (state)
      IDLE:   bus.ready_in = 1'b1;
      COMMIT: begin
        bus.reg_write = wr_q && (rd_addr_q != 5'd0);
        bus.retire    = 1'b1;
      end
      default: ;
    endcase
  end

  // Bytes shifted in from above bit 63 are zero, so misaligned loads read zeros.
  always_comb begin
    shifted = bus.mem_rsp_data >> {lo_pend, 3'b000};
    case (f3_pend)
      3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Pending fields stay separate so rd_addr/rd_data only change on entry to COMMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wr_q      <= 1'b0;
      rd_pend   <= '0;
      wr_pend   <= 1'b0;
      f3_pend   <= '0;
      lo_pend   <= '0;
    end else if (state == IDLE && bus.valid_in) begin
      rd_pend <= bus.rd_addr_in;
      wr_pend <= bus.reg_write_in;
      f3_pend <= bus.funct3;
      lo_pend <= bus.addr_lo;
      if (!bus.mem_read) begin
        rd_addr_q <= bus.rd_addr_in;
        rd_data_q <= bus.alu_result;
        wr_q      <= bus.reg_write_in;
      end
    end else if (state == WAIT_MEM && bus.mem_rsp_valid) begin
      rd_addr_q <= rd_pend;
      rd_data_q <= load_data;
      wr_q      <= wr_pend;
    end
  end

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 instret <= '0;
    else if (state == COMMIT) instret <= instret + 64'd1;
  end
`endif

endmodule
